// File: rtl/spdif_frame_seq.sv
// ---------------------------------------------------------------------------
// spdif_frame_seq
//
// Frame sequencer sitting between the S/PDIF biphase/preamble decoder and the
// mixer datapath. Takes decoded subframes tagged with their preamble, checks
// the B/M/W ordering, tracks the frame index inside a channel-status block,
// declares lock after a run of clean frames, and emits left/right sample
// pairs, per-pair parity status and assembled channel-status bytes.
//
// Parameters
//   FRAMES_PER_BLOCK : frames per channel-status block (multiple of 8, 8..256)
//   LOCK_FRAMES      : consecutive good frames (counted from a B) to lock
//
// Ports
//   clk              : system clock
//   rst              : asynchronous active-low reset
//   sub_valid_i      : one-cycle strobe, a decoded subframe is present
//   sub_pre_i[1:0]   : preamble of that subframe (00 invalid, 01 B, 10 M, 11 W)
//   sub_data_i[23:0] : audio bits
//   sub_ctl_i[3:0]   : [0]=V [1]=U [2]=C [3]=P
//   dec_err_i        : one-cycle biphase-violation pulse from the decoder
//   lock_o           : sequence locked
//   pair_valid_o     : one-cycle strobe for left_o/right_o/pair_perr_o
//   left_o/right_o   : channel A / channel B samples (held between strobes)
//   pair_perr_o      : parity error in either subframe of the pair
//   frame_idx_o      : index of the last completed frame
//   block_start_o    : pulses with pair_valid_o when frame_idx_o == 0
//   cs_byte_o        : channel-status byte, bit0 = earliest frame
//   cs_byte_valid_o  : one-cycle strobe for cs_byte_o
//   err_cnt_o        : saturating error counter, cleared only by reset
// ---------------------------------------------------------------------------
module spdif_frame_seq #(
    parameter int FRAMES_PER_BLOCK = 192,
    parameter int LOCK_FRAMES      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sub_valid_i,
    input  logic [1:0]  sub_pre_i,
    input  logic [23:0] sub_data_i,
    input  logic [3:0]  sub_ctl_i,
    input  logic        dec_err_i,
    output logic        lock_o,
    output logic        pair_valid_o,
    output logic [23:0] left_o,
    output logic [23:0] right_o,
    output logic        pair_perr_o,
    output logic [7:0]  frame_idx_o,
    output logic        block_start_o,
    output logic [7:0]  cs_byte_o,
    output logic        cs_byte_valid_o,
    output logic [7:0]  err_cnt_o
);

    localparam logic [1:0] PRE_B = 2'b01;
    localparam logic [1:0] PRE_M = 2'b10;
    localparam logic [1:0] PRE_W = 2'b11;

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);
    localparam int         GW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        EXP_R = 2'd1,
        EXP_L = 2'd2
    } state_t;

    state_t state, state_nx;

    // Frame assembly state
    logic [7:0]    frame_cnt;   // frame currently being assembled
    logic [23:0]   left_lat;    // left sample waiting for its right partner
    logic          left_perr;   // parity failure on the latched left
    logic [7:0]    cs_sr;       // C bits, newest enters at bit 7
    logic [GW-1:0] good_cnt;    // clean frames since the last restart

    // Decode of the current input
    logic sub_perr;
    logic is_b;
    logic is_w;
    logic left_ok;

    // Per-cycle actions
    logic take_left;
    logic complete;
    logic violation;
    logic seq_err;
    logic par_err;

    logic          pair_perr;
    logic [GW-1:0] good_nx;
    logic          lock_nx;
    logic [1:0]    err_inc;
    logic [8:0]    err_sum;

    // Even parity over bits 4..31: data plus V/U/C/P must XOR to zero.
    assign sub_perr = ^{sub_data_i, sub_ctl_i};
    assign is_b     = sub_valid_i && (sub_pre_i == PRE_B);
    assign is_w     = sub_valid_i && (sub_pre_i == PRE_W);

    // The left after the last frame of a block must carry B, otherwise M.
    assign left_ok  = sub_valid_i &&
                      ((frame_cnt == LAST_FRAME) ? (sub_pre_i == PRE_B)
                                                 : (sub_pre_i == PRE_M));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= HUNT;
        else      state <= state_nx;
    end

    // -----------------------------------------------------------------------
    // Output / action decode
    // -----------------------------------------------------------------------
    always_comb begin
        take_left = 1'b0;
        complete  = 1'b0;
        violation = 1'b0;
        seq_err   = 1'b0;
        case (state)
            HUNT: begin
                take_left = is_b;
            end
            EXP_R: begin
                seq_err   = sub_valid_i && !is_w;
                violation = dec_err_i || seq_err;
                complete  = is_w && !dec_err_i;
            end
            EXP_L: begin
                seq_err   = sub_valid_i && !left_ok;
                violation = dec_err_i || seq_err;
                // An out-of-place B still counts as a violation but is taken
                // as the start of a new block rather than thrown away.
                take_left = !dec_err_i && (left_ok || is_b);
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            HUNT:    if (is_b)      state_nx = EXP_R;
            EXP_R:   if (violation) state_nx = HUNT;
                     else if (complete) state_nx = EXP_L;
            EXP_L:   if (take_left) state_nx = EXP_R;
                     else if (violation) state_nx = HUNT;
            default: state_nx = HUNT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Lock and error bookkeeping
    // -----------------------------------------------------------------------
    assign pair_perr = left_perr | sub_perr;
    assign good_nx   = pair_perr ? '0
                     : (good_cnt == LOCK_CNT) ? LOCK_CNT : good_cnt + 1'b1;
    assign lock_nx   = lock_o || (good_nx == LOCK_CNT);

    // Parity only counts on subframes that were actually accepted.
    assign par_err   = sub_perr && (take_left || complete);
    assign err_inc   = {1'b0, dec_err_i} + {1'b0, seq_err} + {1'b0, par_err};
    assign err_sum   = {1'b0, err_cnt_o} + {7'd0, err_inc};

    // -----------------------------------------------------------------------
    // Frame assembly
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            left_lat  <= '0;
            left_perr <= 1'b0;
            cs_sr     <= '0;
        end else if (take_left) begin
            left_lat  <= sub_data_i;
            left_perr <= sub_perr;
            cs_sr     <= {sub_ctl_i[2], cs_sr[7:1]};
            frame_cnt <= is_b ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_cnt <= '0;
            lock_o   <= 1'b0;
        end else if (violation) begin
            good_cnt <= '0;
            lock_o   <= 1'b0;
        end else if (state == HUNT && is_b) begin
            good_cnt <= '0;
        end else if (complete) begin
            good_cnt <= good_nx;
            lock_o   <= lock_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_o <= '0;
        else      err_cnt_o <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    // -----------------------------------------------------------------------
    // Pair / channel-status outputs (registered, one cycle after the W)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_valid_o    <= 1'b0;
            left_o          <= '0;
            right_o         <= '0;
            pair_perr_o     <= 1'b0;
            frame_idx_o     <= '0;
            block_start_o   <= 1'b0;
            cs_byte_o       <= '0;
            cs_byte_valid_o <= 1'b0;
        end else begin
            pair_valid_o    <= 1'b0;
            block_start_o   <= 1'b0;
            cs_byte_valid_o <= 1'b0;
            if (complete) begin
                frame_idx_o <= frame_cnt;
                if (lock_nx) begin
                    pair_valid_o  <= 1'b1;
                    left_o        <= left_lat;
                    right_o       <= sub_data_i;
                    pair_perr_o   <= pair_perr;
                    block_start_o <= (frame_cnt == 8'd0);
                    // Frames are counted from 0 at each B, so the shift
                    // register holds exactly frames idx-7..idx here.
                    if (frame_cnt[2:0] == 3'd7) begin
                        cs_byte_o       <= cs_sr;
                        cs_byte_valid_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_frame_seq.sv
module tb_spdif_frame_seq;
    localparam int FPB = 192;
    localparam int LF  = 4;
    localparam logic [1:0] PB = 2'b01;
    localparam logic [1:0] PM = 2'b10;
    localparam logic [1:0] PW = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sub_valid_i = 1'b0;
    logic [1:0]  sub_pre_i = 2'b00;
    logic [23:0] sub_data_i = '0;
    logic [3:0]  sub_ctl_i = '0;
    logic        dec_err_i = 1'b0;
    logic        lock_o, pair_valid_o, pair_perr_o, block_start_o, cs_byte_valid_o;
    logic [23:0] left_o, right_o;
    logic [7:0]  frame_idx_o, cs_byte_o, err_cnt_o;

    spdif_frame_seq #(.FRAMES_PER_BLOCK(FPB), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .rst(rst),
        .sub_valid_i(sub_valid_i), .sub_pre_i(sub_pre_i), .sub_data_i(sub_data_i),
        .sub_ctl_i(sub_ctl_i), .dec_err_i(dec_err_i),
        .lock_o(lock_o), .pair_valid_o(pair_valid_o), .left_o(left_o), .right_o(right_o),
        .pair_perr_o(pair_perr_o), .frame_idx_o(frame_idx_o), .block_start_o(block_start_o),
        .cs_byte_o(cs_byte_o), .cs_byte_valid_o(cs_byte_valid_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sc    = 0;   // running subframe counter used as sample data

    // Model: pos is the index of the next expected subframe within the block
    // (even = left, odd = right), -1 while searching for a B.
    int          pos;
    int          run;
    bit          mlock;
    logic [23:0] hl;
    bit          hperr;
    bit          cb[8];
    // Expected outputs after the next clock edge
    bit          e_lock, e_pv, e_perr, e_bs, e_csv;
    logic [23:0] e_left, e_right;
    logic [7:0]  e_idx, e_cs;
    int          e_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mk(input logic [23:0] d, input bit c, input bit flip);
        logic p;
        p = (^d) ^ c ^ flip;
        return {p, c, 1'b0, 1'b0};
    endfunction

    task automatic model_reset();
        pos = -1; run = 0; mlock = 0; hl = '0; hperr = 0;
        for (int i = 0; i < 8; i++) cb[i] = 0;
        e_lock = 0; e_pv = 0; e_perr = 0; e_bs = 0; e_csv = 0;
        e_left = '0; e_right = '0; e_idx = '0; e_cs = '0; e_err = 0;
    endtask

    task automatic hold_left(input logic [23:0] d, input logic [3:0] c, input bit par, input int fr);
        hl = d; hperr = par; cb[fr % 8] = c[2];
    endtask

    task automatic model(input bit v, input logic [1:0] p, input logic [23:0] d,
                         input logic [3:0] c, input bit de);
        bit par, badp, pp;
        int inc, fr;
        logic [1:0] want;
        par = ^{d, c};
        inc = 0;
        e_pv = 0; e_csv = 0; e_bs = 0;
        if (pos < 0) begin
            inc += int'(de);
            if (v && p == PB) begin
                hold_left(d, c, par, 0); inc += int'(par); pos = 1; run = 0;
            end
        end else begin
            want = (pos % 2 == 1) ? PW : ((pos == 0) ? PB : PM);
            badp = v && (p != want);
            inc += int'(de) + int'(badp);
            if (de || badp) begin
                mlock = 0; run = 0;
                if (!de && v && p == PB && pos % 2 == 0) begin
                    hold_left(d, c, par, 0); inc += int'(par); pos = 1;
                end else begin
                    pos = -1;
                end
            end else if (v) begin
                inc += int'(par);
                if (pos % 2 == 0) begin
                    hold_left(d, c, par, pos / 2); pos++;
                end else begin
                    fr  = pos / 2;
                    pp  = hperr | par;
                    run = pp ? 0 : ((run < LF) ? run + 1 : LF);
                    if (run == LF) mlock = 1;
                    e_idx = 8'(fr);
                    if (mlock) begin
                        e_pv = 1; e_left = hl; e_right = d; e_perr = pp; e_bs = (fr == 0);
                        if (fr % 8 == 7) begin
                            e_csv = 1;
                            for (int i = 0; i < 8; i++) e_cs[i] = cb[i];
                        end
                    end
                    pos = (pos + 1) % (2 * FPB);
                end
            end
        end
        e_err  = (e_err + inc > 255) ? 255 : e_err + inc;
        e_lock = mlock;
    endtask

    task automatic compare();
        chk("lock",   32'(lock_o),          32'(e_lock));
        chk("pv",     32'(pair_valid_o),    32'(e_pv));
        chk("err",    32'(err_cnt_o),       32'(e_err));
        chk("idx",    32'(frame_idx_o),     32'(e_idx));
        chk("bstart", 32'(block_start_o),   32'(e_bs));
        chk("csv",    32'(cs_byte_valid_o), 32'(e_csv));
        if (e_pv) begin
            chk("left",  32'(left_o),      32'(e_left));
            chk("right", 32'(right_o),     32'(e_right));
            chk("perr",  32'(pair_perr_o), 32'(e_perr));
        end
        if (e_csv) chk("csbyte", 32'(cs_byte_o), 32'(e_cs));
    endtask

    task automatic tick(input bit v, input logic [1:0] p, input logic [23:0] d,
                        input logic [3:0] c, input bit de);
        @(negedge clk);
        sub_valid_i = v; sub_pre_i = p; sub_data_i = d; sub_ctl_i = c; dec_err_i = de;
        model(v, p, d, c, de);
        @(posedge clk);
        #1;
        compare();
        sub_valid_i = 1'b0; dec_err_i = 1'b0;
    endtask

    task automatic idle();
        tick(0, 2'b00, 24'd0, 4'd0, 0);
    endtask

    task automatic send_frame(input logic [1:0] lpre, input bit c, input bit flipr);
        tick(1, lpre, 24'(sc),     mk(24'(sc), c, 0),         0);
        tick(1, PW,   24'(sc + 1), mk(24'(sc + 1), 0, flipr), 0);
        sc += 2;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_lock"},  32'(lock_o),          32'd0);
        chk({tag, "_pv"},    32'(pair_valid_o),    32'd0);
        chk({tag, "_left"},  32'(left_o),          32'd0);
        chk({tag, "_right"}, 32'(right_o),         32'd0);
        chk({tag, "_err"},   32'(err_cnt_o),       32'd0);
        chk({tag, "_idx"},   32'(frame_idx_o),     32'd0);
        chk({tag, "_cs"},    32'(cs_byte_o),       32'd0);
        chk({tag, "_csv"},   32'(cs_byte_valid_o), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst0");
        @(negedge clk);
        rst = 1'b1;

        // No B: everything ignored
        tick(1, PW, 24'd1, mk(24'd1, 0, 0), 0);
        tick(1, PM, 24'd2, mk(24'd2, 0, 0), 0);
        tick(1, PW, 24'd3, mk(24'd3, 0, 0), 0);
        chk("nob_lock", 32'(lock_o), 32'd0);
        chk("nob_err",  32'(err_cnt_o), 32'd0);

        // Block 0: clean stream, C on frames 0 and 2, bad P on right of frame 20
        for (int f = 0; f < FPB; f++) begin
            send_frame((f == 0) ? PB : PM, (f == 0 || f == 2), (f == 20));
            if (f == 2) chk("f2_lock", 32'(lock_o), 32'd0);
            if (f == 3) begin
                chk("f3_lock",  32'(lock_o),       32'd1);
                chk("f3_pv",    32'(pair_valid_o), 32'd1);
                chk("f3_left",  32'(left_o),       32'd6);
                chk("f3_right", 32'(right_o),      32'd7);
                chk("f3_idx",   32'(frame_idx_o),  32'd3);
            end
            if (f == 7) begin
                chk("f7_csv", 32'(cs_byte_valid_o), 32'd1);
                chk("f7_cs",  32'(cs_byte_o),       32'h05);
            end
            if (f == 15) chk("f15_cs", 32'(cs_byte_o), 32'h00);
            if (f == 20) begin
                chk("f20_perr", 32'(pair_perr_o), 32'd1);
                chk("f20_lock", 32'(lock_o),      32'd1);
                chk("f20_err",  32'(err_cnt_o),   32'd1);
            end
            if (f % 5 == 4) idle();
        end

        // Block 1: wrap, then W of frame 10 replaced by M
        send_frame(PB, 0, 0);
        chk("wrap_left",  32'(left_o),        32'd384);
        chk("wrap_right", 32'(right_o),       32'd385);
        chk("wrap_bs",    32'(block_start_o), 32'd1);
        chk("wrap_idx",   32'(frame_idx_o),   32'd0);
        chk("wrap_lock",  32'(lock_o),        32'd1);
        for (int f = 1; f < 10; f++) send_frame(PM, 0, 0);
        tick(1, PM, 24'(sc),     mk(24'(sc), 0, 0),     0);
        tick(1, PM, 24'(sc + 1), mk(24'(sc + 1), 0, 0), 0);
        sc += 2;
        chk("seq_lock", 32'(lock_o),       32'd0);
        chk("seq_err",  32'(err_cnt_o),    32'd2);
        chk("seq_pv",   32'(pair_valid_o), 32'd0);
        for (int f = 11; f < 16; f++) send_frame(PM, 0, 0);

        // Block 2: relock, then an early B taken as a new block start
        for (int f = 0; f < 6; f++) begin
            send_frame((f == 0) ? PB : PM, 0, 0);
            if (f == 2) chk("relock2", 32'(lock_o), 32'd0);
            if (f == 3) chk("relock3", 32'(lock_o), 32'd1);
        end
        tick(1, PB, 24'(sc), mk(24'(sc), 0, 0), 0);
        chk("exc_lock", 32'(lock_o),    32'd0);
        chk("exc_err",  32'(err_cnt_o), 32'd3);
        tick(1, PW, 24'(sc + 1), mk(24'(sc + 1), 0, 0), 0);
        sc += 2;
        for (int f = 1; f < 5; f++) begin
            send_frame(PM, 0, 0);
            if (f == 3) begin
                chk("exc_relock", 32'(lock_o),      32'd1);
                chk("exc_idx",    32'(frame_idx_o), 32'd3);
            end
        end

        // Decoder error between left and right
        tick(1, PM, 24'(sc), mk(24'(sc), 0, 0), 0);
        sc += 1;
        tick(0, 2'b00, 24'd0, 4'd0, 1);
        chk("derr_err",  32'(err_cnt_o), 32'd4);
        chk("derr_lock", 32'(lock_o),    32'd0);

        // Reset in the middle of a frame
        tick(1, PB, 24'(sc), mk(24'(sc), 0, 0), 0);
        sc += 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        reset_checks("rst1");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(1, PW, 24'(sc), mk(24'(sc), 0, 0), 0);
        sc += 1;
        for (int f = 0; f < 5; f++) send_frame((f == 0) ? PB : PM, 0, 0);
        chk("post_rst_lock", 32'(lock_o), 32'd1);

        // Error counter saturation
        repeat (260) tick(0, 2'b00, 24'd0, 4'd0, 1);
        chk("err_sat", 32'(err_cnt_o), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
